// File: rtl/timekeeper_pkg.sv
// Shared types and BCD helpers for the alarm timekeeper.
// Fields are packed two-digit BCD bytes: SS in [7:0], MM in [15:8], HH in [23:16].
package timekeeper_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } ch_state_e;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  // Maximum BCD value of field idx (0 = SS, 1 = MM, 2 = HH).
  function automatic logic [7:0] field_max(input int unsigned idx);
    logic [7:0] m;
    case (idx)
      0:       m = SEC_MAX;
      1:       m = MIN_MAX;
      default: m = HOUR_MAX;
    endcase
    return m;
  endfunction

  // Returns {carry, next}; carry is set when the field wraps past max to 00.
  function automatic logic [8:0] bcd_field_inc(input logic [7:0] value, input logic [7:0] max);
    logic [8:0] r;
    if (value == max) begin
      r = {1'b1, 8'h00};
    end else if (value[3:0] == 4'd9) begin
      r = {1'b0, value[7:4] + 4'd1, 4'h0};
    end else begin
      r = {1'b0, value[7:4], value[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic bcd_field_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: alarm register plus the IDLE/RINGING/SNOOZED ring state machine.
// A match is taken against the time value the counter is about to advance to.
module alarm_channel
  import timekeeper_pkg::*;
#(
  parameter int unsigned TW          = 16,
  parameter int unsigned RING_SECS   = 30,
  parameter int unsigned SNOOZE_SECS = 60
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          tick_i,
  input  logic          ack_i,
  input  logic          snooze_i,
  input  logic          en_i,
  input  logic          wr_i,
  input  logic [TW-1:0] wdata_i,
  input  logic [TW-1:0] next_time_i,
  output logic          ringing_o
);

  localparam int unsigned CMAX  = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int unsigned CNT_W = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_RINGING = RINGING;
  localparam logic [1:0] S_SNOOZED = SNOOZED;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
  logic [CNT_W-1:0] ring_inc;
  logic [TW-1:0]    alarm_q, alarm_d;
  logic             ringing_q, ringing_d;
  logic             match;

  assign match    = tick_i && (next_time_i == alarm_q);
  assign ring_inc = ring_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      alarm_q    <= '0;
      ringing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      alarm_q    <= alarm_d;
      ringing_q  <= ringing_d;
    end
  end

  // ack beats snooze, snooze beats a timeout on the same tick.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    alarm_d    = alarm_q;
    if (wr_i) begin
      alarm_d = wdata_i;
    end
    case (state_q)
      S_IDLE: begin
        if (match && en_i) begin
          state_d    = S_RINGING;
          ring_cnt_d = '0;
        end
      end
      S_RINGING: begin
        if (ack_i || !en_i) begin
          state_d = S_IDLE;
        end else if (snooze_i) begin
          state_d   = S_SNOOZED;
          snz_cnt_d = CNT_W'(SNOOZE_SECS);
        end else if (tick_i) begin
          ring_cnt_d = ring_inc;
          if (ring_inc == CNT_W'(RING_SECS)) begin
            state_d = S_IDLE;
          end
        end
      end
      S_SNOOZED: begin
        if (ack_i || !en_i) begin
          state_d = S_IDLE;
        end else if (tick_i) begin
          if (snz_cnt_q <= CNT_W'(1)) begin
            state_d    = S_RINGING;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
          end else begin
            snz_cnt_d = snz_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ringing_d = (state_d == S_RINGING);
  end

  assign ringing_o = ringing_q;

endmodule

// File: rtl/alarm_timekeeper.sv
// BCD MM:SS / HH:MM:SS time counter with validated load and N independent alarm channels.
// A load in the same cycle as a tick swallows the tick entirely.
module alarm_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int unsigned HOURS_EN    = 0,
  parameter int unsigned N_ALARMS    = 2,
  parameter int unsigned RING_SECS   = 30,
  parameter int unsigned SNOOZE_SECS = 60,
  localparam int unsigned TW = (HOURS_EN != 0) ? 24 : 16,
  localparam int unsigned AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                tick,
  input  logic                load,
  input  logic [TW-1:0]       load_time,
  output logic [TW-1:0]       time_bcd,
  output logic                rollover,
  input  logic                alarm_wr,
  input  logic [AW-1:0]       alarm_sel,
  input  logic [TW-1:0]       alarm_wdata,
  input  logic [N_ALARMS-1:0] alarm_en,
  input  logic                ack,
  input  logic                snooze,
  output logic [N_ALARMS-1:0] ringing,
  output logic                ring_any
);

  localparam int unsigned NF = TW / 8;

  // Any out-of-range or non-decimal field is replaced by 00; others pass through.
  function automatic logic [TW-1:0] validate(input logic [TW-1:0] t);
    logic [TW-1:0] v;
    v = t;
    for (int unsigned f = 0; f < NF; f++) begin
      if (!bcd_field_valid(t[f*8 +: 8], field_max(f))) begin
        v[f*8 +: 8] = 8'h00;
      end
    end
    return v;
  endfunction

  logic [TW-1:0] time_q, time_d, time_inc;
  logic          rollover_q, rollover_d;
  logic [NF:0]   carry;
  logic [8:0]    inc_r;
  logic          tick_eff;

  assign tick_eff = tick && !load;

  // Ripple the carry from seconds upward within one edge.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    time_inc = time_q;
    inc_r    = '0;
    for (int unsigned f = 0; f < NF; f++) begin
      inc_r = bcd_field_inc(time_q[f*8 +: 8], field_max(f));
      if (carry[f]) begin
        time_inc[f*8 +: 8] = inc_r[7:0];
      end
      carry[f+1] = carry[f] & inc_r[8];
    end
  end

  always_comb begin
    time_d     = time_q;
    rollover_d = 1'b0;
    if (load) begin
      time_d = validate(load_time);
    end else if (tick) begin
      time_d     = time_inc;
      rollover_d = carry[NF];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      time_q     <= '0;
      rollover_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      rollover_q <= rollover_d;
    end
  end

  assign time_bcd = time_q;
  assign rollover = rollover_q;

  logic [TW-1:0] wdata_valid;
  assign wdata_valid = validate(alarm_wdata);

  // Select values beyond the last channel decode to no channel.
  for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
    logic wr_ch;
    assign wr_ch = alarm_wr && (alarm_sel == AW'(i));

    alarm_channel #(
      .TW          (TW),
      .RING_SECS   (RING_SECS),
      .SNOOZE_SECS (SNOOZE_SECS)
    ) u_ch (
      .clk         (clk),
      .resetn      (resetn),
      .tick_i      (tick_eff),
      .ack_i       (ack),
      .snooze_i    (snooze),
      .en_i        (alarm_en[i]),
      .wr_i        (wr_ch),
      .wdata_i     (wdata_valid),
      .next_time_i (time_inc),
      .ringing_o   (ringing[i])
    );
  end

  assign ring_any = |ringing;

endmodule
